// File: rtl/seq_step_controller.sv
// seq_step_controller
//
// Sequencer for the 3-bit random-sequence counter. A small table of count
// values is programmed while idle; on start the controller clears the
// counter for one cycle and then steps it through table[0..last_idx],
// holding each entry for STEP_CYC cycles and wrapping back to entry 0.
// The counter feedback is compared against the value that was loaded one
// cycle earlier. The first mismatch sets a sticky error and parks the
// counter at zero.
//
// Ports
//   clk        rising-edge clock
//   clear_n    synchronous active-low reset
//   wr_en      table write strobe (honoured only while idle)
//   wr_addr    table write address (ignored when >= DEPTH)
//   wr_data    table write data
//   last_idx   index of last sequence entry, latched at start, clamped
//   start      begin a sequence from idle or error
//   stop       abort to idle, wins over everything except reset
//   count      counter output feedback
//   ctr_in     value the counter loads when ctr_clear is low
//   ctr_clear  forces the counter to zero at the next edge
//   busy       high while clearing or running
//   step_idx   current table index
//   wrap       one-cycle pulse when step_idx returns from last_idx to 0
//   err        sticky mismatch flag
module seq_step_controller #(
  parameter int WIDTH    = 3,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int STEP_CYC = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    last_idx,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] ctr_in,
  output logic             ctr_clear,
  output logic             busy,
  output logic [AW-1:0]    step_idx,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_ERR
  } state_t;

  // Hold counter only needs to reach STEP_CYC-1; keep at least one bit.
  localparam int HW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_CYC - 1);
  localparam logic [AW-1:0] IDX_MAX   = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];
  logic [AW-1:0]    last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             chk_v_q, chk_v_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [AW-1:0]    exp_idx_q, exp_idx_d;
  logic [WIDTH-1:0] ctr_in_q, ctr_in_d;
  logic             ctr_clear_q, ctr_clear_d;
  logic             busy_q, busy_d;
  logic [AW-1:0]    step_idx_q, step_idx_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             addr_ok;
  logic [AW-1:0]    last_clamped;
  logic [AW-1:0]    next_idx;
  logic             at_last;
  logic             mismatch;

  assign addr_ok      = (32'(wr_addr) < DEPTH);
  assign last_clamped = (last_idx > IDX_MAX) ? IDX_MAX : last_idx;
  assign at_last      = (step_idx_q == last_q);
  assign next_idx     = at_last ? '0 : step_idx_q + AW'(1);

  // The checker compares against the value loaded one cycle earlier, and
  // only while still running so a stale arm after stop/error is ignored.
  assign mismatch = chk_v_q && (state_q == ST_RUN) && (count != exp_q);

  // Next-state and registered-output logic. exp_idx remembers which table
  // index produced the checked value so an error parks step_idx on the
  // failing entry rather than on the entry already being driven.
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    last_d      = last_q;
    hold_d      = hold_q;
    ctr_in_d    = ctr_in_q;
    ctr_clear_d = ctr_clear_q;
    busy_d      = busy_q;
    step_idx_d  = step_idx_q;
    wrap_d      = 1'b0;
    err_d       = err_q;
    chk_v_d     = (state_q == ST_RUN);
    exp_d       = ctr_in_q;
    exp_idx_d   = step_idx_q;

    if (wr_en && (state_q == ST_IDLE) && addr_ok) begin
      table_d[wr_addr] = wr_data;
    end

    if (stop) begin
      state_d     = ST_IDLE;
      ctr_clear_d = 1'b1;
      ctr_in_d    = '0;
      busy_d      = 1'b0;
      step_idx_d  = '0;
      hold_d      = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state_d     = ST_CLR;
            last_d      = last_clamped;
            ctr_clear_d = 1'b1;
            ctr_in_d    = '0;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            step_idx_d  = '0;
            hold_d      = '0;
          end
        end
        ST_CLR: begin
          state_d     = ST_RUN;
          ctr_clear_d = 1'b0;
          ctr_in_d    = table_q[0];
          busy_d      = 1'b1;
          step_idx_d  = '0;
          hold_d      = '0;
        end
        ST_RUN: begin
          if (mismatch) begin
            state_d     = ST_ERR;
            err_d       = 1'b1;
            ctr_clear_d = 1'b1;
            ctr_in_d    = '0;
            busy_d      = 1'b0;
            step_idx_d  = exp_idx_q;
            hold_d      = '0;
          end else if (hold_q == HOLD_LAST) begin
            step_idx_d = next_idx;
            ctr_in_d   = table_q[next_idx];
            hold_d     = '0;
            wrap_d     = at_last;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      chk_v_q     <= 1'b0;
      exp_q       <= '0;
      exp_idx_q   <= '0;
      ctr_in_q    <= '0;
      ctr_clear_q <= 1'b1;
      busy_q      <= 1'b0;
      step_idx_q  <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      chk_v_q     <= chk_v_d;
      exp_q       <= exp_d;
      exp_idx_q   <= exp_idx_d;
      ctr_in_q    <= ctr_in_d;
      ctr_clear_q <= ctr_clear_d;
      busy_q      <= busy_d;
      step_idx_q  <= step_idx_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign ctr_in    = ctr_in_q;
  assign ctr_clear = ctr_clear_q;
  assign busy      = busy_q;
  assign step_idx  = step_idx_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule
